// File: rtl/ucie_thermal_pkg.sv
// Shared types and default constants for the UCIe thermal throttle controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ucie_thermal_pkg;

  // Throttle severity, ordered so that a numeric compare gives severity order.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LIGHT  = 2'd1,
    MEDIUM = 2'd2,
    HEAVY  = 2'd3
  } throttle_level_e;

  localparam int T_INIT_DEF       = 25;
  localparam int T_LIGHT_DEF      = 85;
  localparam int T_MED_DEF        = 95;
  localparam int T_HEAVY_DEF      = 105;
  localparam int HYST_DEF         = 5;
  localparam int DWELL_SWEEPS_DEF = 4;
  localparam int ZONE_THRESH_DEF  = 100;

  // Sensors per thermal zone.
  localparam int ZONE_SIZE = 8;

  // De-escalation threshold for a level; saturates at 0 so a small threshold
  // with a large hysteresis can never wrap to a huge unsigned value.
  function automatic int deesc_thresh(input int t, input int h);
    return (t > h) ? (t - h) : 0;
  endfunction

endpackage

// File: rtl/ucie_thermal_scanner.sv
// Sensor scanner: walks one sensor per enabled cycle, accumulating sum/max/valid count/zone flags.
// Latency: sweep results (fin_*) are presented combinationally with sweep_end on the last index; sweep_done follows as a registered pulse.
// Backpressure: none; enable=0 discards the partial sweep and restarts at index 0.
//
// Ports:
//   clk_app, rst_n       clock, synchronous active-low reset
//   enable               scan enable
//   sensor_data/valid    per-sensor readings and valid bits
//   cur_avg              currently published average, substituted for invalid sensors
//   sweep_end            high in the cycle sampling the last sensor (comb)
//   fin_avg/max/zone     sweep results including the last sensor (comb)
//   fin_any_valid        at least one valid sensor in this sweep (comb)
//   sweep_done           registered one-cycle pulse, coincident with top-level result registers
module ucie_thermal_scanner
  import ucie_thermal_pkg::*;
#(
  parameter int NUM_SENSORS = 64,
  parameter int TEMP_W      = 8,
  parameter int ZONE_THRESH = ZONE_THRESH_DEF
) (
  input  logic                                clk_app,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [NUM_SENSORS-1:0][TEMP_W-1:0]  sensor_data,
  input  logic [NUM_SENSORS-1:0]              sensor_valid,
  input  logic [TEMP_W-1:0]                   cur_avg,
  output logic                                sweep_end,
  output logic [TEMP_W-1:0]                   fin_avg,
  output logic [TEMP_W-1:0]                   fin_max,
  output logic [NUM_SENSORS/ZONE_SIZE-1:0]    fin_zone,
  output logic                                fin_any_valid,
  output logic                                sweep_done
);

  localparam int IDX_W     = $clog2(NUM_SENSORS);
  localparam int SUM_W     = TEMP_W + IDX_W;
  localparam int CNT_W     = IDX_W + 1;
  localparam int NUM_ZONES = NUM_SENSORS / ZONE_SIZE;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SENSORS - 1);
  localparam logic [TEMP_W-1:0] ZT       = TEMP_W'(ZONE_THRESH);

  logic [IDX_W-1:0]     idx_q;
  logic [SUM_W-1:0]     sum_q;
  logic [TEMP_W-1:0]    max_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_ZONES-1:0] zone_q;

  logic [TEMP_W-1:0]    samp;
  logic                 samp_vld;
  logic [TEMP_W-1:0]    add_val;
  logic [SUM_W-1:0]     sum_nxt;
  logic [TEMP_W-1:0]    max_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [NUM_ZONES-1:0] zone_nxt;
  logic                 hot;

  always_comb begin
    samp     = sensor_data[idx_q];
    samp_vld = sensor_valid[idx_q];
    // An invalid sensor contributes the current average, which keeps the
    // divisor fixed at NUM_SENSORS so the average is a plain shift.
    add_val  = samp_vld ? samp : cur_avg;
    sum_nxt  = sum_q + SUM_W'(add_val);
    max_nxt  = (samp_vld && (samp > max_q)) ? samp : max_q;
    cnt_nxt  = cnt_q + CNT_W'(samp_vld);
    hot      = samp_vld && (samp >= ZT);
    zone_nxt = zone_q;
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (hot && ((int'(idx_q) / ZONE_SIZE) == z)) begin
        zone_nxt[z] = 1'b1;
      end
    end
  end

  assign sweep_end     = enable && (idx_q == LAST_IDX);
  assign fin_avg       = TEMP_W'(sum_nxt >> IDX_W);
  assign fin_max       = max_nxt;
  assign fin_zone      = zone_nxt;
  assign fin_any_valid = (cnt_nxt != '0);

  always_ff @(posedge clk_app) begin
    if (!rst_n || !enable) begin
      idx_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      zone_q     <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= sweep_end;
      if (sweep_end) begin
        idx_q  <= '0;
        sum_q  <= '0;
        max_q  <= '0;
        cnt_q  <= '0;
        zone_q <= '0;
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
        sum_q  <= sum_nxt;
        max_q  <= max_nxt;
        cnt_q  <= cnt_nxt;
        zone_q <= zone_nxt;
      end
    end
  end

endmodule

// File: rtl/ucie_thermal_throttle_ctrl.sv
// Thermal manager: publishes per-sweep average/max/zone alarms and runs the hysteretic throttle FSM.
// Latency: results and throttle level update on the edge that samples the last sensor (NUM_SENSORS enabled cycles per sweep).
// Backpressure: none; enable=0 freezes all outputs and FSM state, and the next sweep restarts from sensor 0.
//
// Ports:
//   clk_app, rst_n             clock, synchronous active-low reset
//   enable                     scan enable
//   sensor_data, sensor_valid  per-sensor readings and valid bits
//   die_temperature_avg/max    last sweep average / maximum over valid sensors
//   thermal_throttle_level     0=None 1=Light 2=Medium 3=Heavy
//   thermal_throttle_active    level != 0
//   thermal_zone_status        per-zone alarm (8 sensors per zone)
//   sensor_fault               last sweep had no valid sensor
//   sweep_done                 one-cycle pulse when results update
module ucie_thermal_throttle_ctrl
  import ucie_thermal_pkg::*;
#(
  parameter int NUM_SENSORS  = 64,
  parameter int TEMP_W       = 8,
  parameter int T_INIT       = T_INIT_DEF,
  parameter int T_LIGHT      = T_LIGHT_DEF,
  parameter int T_MED        = T_MED_DEF,
  parameter int T_HEAVY      = T_HEAVY_DEF,
  parameter int HYST         = HYST_DEF,
  parameter int DWELL_SWEEPS = DWELL_SWEEPS_DEF,
  parameter int ZONE_THRESH  = ZONE_THRESH_DEF
) (
  input  logic                                clk_app,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [NUM_SENSORS-1:0][TEMP_W-1:0]  sensor_data,
  input  logic [NUM_SENSORS-1:0]              sensor_valid,
  output logic [TEMP_W-1:0]                   die_temperature_avg,
  output logic [TEMP_W-1:0]                   die_temperature_max,
  output logic [1:0]                          thermal_throttle_level,
  output logic                                thermal_throttle_active,
  output logic [NUM_SENSORS/ZONE_SIZE-1:0]    thermal_zone_status,
  output logic                                sensor_fault,
  output logic                                sweep_done
);

  localparam int NUM_ZONES = NUM_SENSORS / ZONE_SIZE;
  localparam int DWELL_W   = $clog2(DWELL_SWEEPS + 1);

  localparam logic [TEMP_W-1:0] TH_LIGHT = TEMP_W'(T_LIGHT);
  localparam logic [TEMP_W-1:0] TH_MED   = TEMP_W'(T_MED);
  localparam logic [TEMP_W-1:0] TH_HEAVY = TEMP_W'(T_HEAVY);
  // One extra bit so a de-escalation threshold of 2^TEMP_W-1 plus headroom still compares correctly.
  localparam logic [TEMP_W:0] DE_LIGHT = (TEMP_W+1)'(deesc_thresh(T_LIGHT, HYST));
  localparam logic [TEMP_W:0] DE_MED   = (TEMP_W+1)'(deesc_thresh(T_MED, HYST));
  localparam logic [TEMP_W:0] DE_HEAVY = (TEMP_W+1)'(deesc_thresh(T_HEAVY, HYST));
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_SWEEPS - 1);

  logic                  sweep_end;
  logic [TEMP_W-1:0]     fin_avg;
  logic [TEMP_W-1:0]     fin_max;
  logic [NUM_ZONES-1:0]  fin_zone;
  logic                  fin_any_valid;

  throttle_level_e       level_q;
  logic [DWELL_W-1:0]    dwell_q;
  throttle_level_e       tgt;
  logic [TEMP_W:0]       de_thr;

  ucie_thermal_scanner #(
    .NUM_SENSORS (NUM_SENSORS),
    .TEMP_W      (TEMP_W),
    .ZONE_THRESH (ZONE_THRESH)
  ) u_scanner (
    .clk_app       (clk_app),
    .rst_n         (rst_n),
    .enable        (enable),
    .sensor_data   (sensor_data),
    .sensor_valid  (sensor_valid),
    .cur_avg       (die_temperature_avg),
    .sweep_end     (sweep_end),
    .fin_avg       (fin_avg),
    .fin_max       (fin_max),
    .fin_zone      (fin_zone),
    .fin_any_valid (fin_any_valid),
    .sweep_done    (sweep_done)
  );

  // Escalation target from the sweep's new maximum, and the de-escalation
  // threshold belonging to the level we are currently in.
  always_comb begin
    tgt = NONE;
    if (fin_max >= TH_HEAVY) begin
      tgt = HEAVY;
    end else if (fin_max >= TH_MED) begin
      tgt = MEDIUM;
    end else if (fin_max >= TH_LIGHT) begin
      tgt = LIGHT;
    end

    de_thr = '0;
    case (level_q)
      LIGHT:   de_thr = DE_LIGHT;
      MEDIUM:  de_thr = DE_MED;
      HEAVY:   de_thr = DE_HEAVY;
      default: de_thr = '0;
    endcase
  end

  assign thermal_throttle_level = level_q;

  always_ff @(posedge clk_app) begin
    if (!rst_n) begin
      die_temperature_avg     <= TEMP_W'(T_INIT);
      die_temperature_max     <= '0;
      thermal_zone_status     <= '0;
      sensor_fault            <= 1'b0;
      level_q                 <= NONE;
      thermal_throttle_active <= 1'b0;
      dwell_q                 <= '0;
    end else if (sweep_end) begin
      if (!fin_any_valid) begin
        // No trustworthy reading: hold published temperatures and fail safe.
        sensor_fault            <= 1'b1;
        level_q                 <= HEAVY;
        thermal_throttle_active <= 1'b1;
        dwell_q                 <= '0;
      end else begin
        die_temperature_avg <= fin_avg;
        die_temperature_max <= fin_max;
        thermal_zone_status <= fin_zone;
        sensor_fault        <= 1'b0;
        if (tgt > level_q) begin
          level_q                 <= tgt;
          thermal_throttle_active <= 1'b1;
          dwell_q                 <= '0;
        end else if ((level_q != NONE) && ({1'b0, fin_max} < de_thr)) begin
          if (dwell_q == DWELL_LAST) begin
            level_q                 <= throttle_level_e'(level_q - 2'd1);
            thermal_throttle_active <= (level_q != LIGHT);
            dwell_q                 <= '0;
          end else begin
            dwell_q <= dwell_q + DWELL_W'(1);
          end
        end else begin
          dwell_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucie_thermal_throttle_ctrl.sv
module tb_ucie_thermal_throttle_ctrl;

  localparam int N  = 64;
  localparam int TW = 8;
  localparam int NZ = N / 8;

  logic                    clk_app;
  logic                    rst_n;
  logic                    enable;
  logic [N-1:0][TW-1:0]    sensor_data;
  logic [N-1:0]            sensor_valid;
  logic [TW-1:0]           die_temperature_avg;
  logic [TW-1:0]           die_temperature_max;
  logic [1:0]              thermal_throttle_level;
  logic                    thermal_throttle_active;
  logic [NZ-1:0]           thermal_zone_status;
  logic                    sensor_fault;
  logic                    sweep_done;

  ucie_thermal_throttle_ctrl dut (
    .clk_app                 (clk_app),
    .rst_n                   (rst_n),
    .enable                  (enable),
    .sensor_data             (sensor_data),
    .sensor_valid            (sensor_valid),
    .die_temperature_avg     (die_temperature_avg),
    .die_temperature_max     (die_temperature_max),
    .thermal_throttle_level  (thermal_throttle_level),
    .thermal_throttle_active (thermal_throttle_active),
    .thermal_zone_status     (thermal_zone_status),
    .sensor_fault            (sensor_fault),
    .sweep_done              (sweep_done)
  );

  initial clk_app = 1'b0;
  always #5 clk_app = ~clk_app;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Records what each sensor looked like in the cycle it was scanned, and at
  // the end of a sweep derives the published values from the whole array.
  int  m_avg, m_max, m_level, m_dwell, m_pos;
  bit  m_fault, m_done, m_ok;
  logic [NZ-1:0] m_zone;
  int  s_dat [N];
  bit  s_vld [N];
  int  thr [4] = '{0, 85, 95, 105};

  task automatic model_sweep_end();
    int sum, mx, nv, tgt;
    logic [NZ-1:0] z;
    sum = 0; mx = 0; nv = 0; z = '0;
    for (int i = 0; i < N; i++) begin
      if (s_vld[i]) begin
        sum += s_dat[i];
        nv++;
        if (s_dat[i] > mx) mx = s_dat[i];
        if (s_dat[i] >= 100) z[i / 8] = 1'b1;
      end else begin
        sum += m_avg;
      end
    end
    m_done = 1;
    if (nv == 0) begin
      m_fault = 1;
      m_level = 3;
      m_dwell = 0;
      return;
    end
    m_fault = 0;
    m_avg   = sum / N;
    m_max   = mx;
    m_zone  = z;
    tgt = (mx >= 105) ? 3 : (mx >= 95) ? 2 : (mx >= 85) ? 1 : 0;
    if (tgt > m_level) begin
      m_level = tgt;
      m_dwell = 0;
    end else if (m_level > 0 && mx < thr[m_level] - 5) begin
      m_dwell++;
      if (m_dwell == 4) begin
        m_level--;
        m_dwell = 0;
      end
    end else begin
      m_dwell = 0;
    end
  endtask

  initial begin
    m_ok = 0;
    forever begin
      @(posedge clk_app);
      m_done = 0;
      if (!rst_n) begin
        m_avg = 25; m_max = 0; m_level = 0; m_dwell = 0; m_pos = 0;
        m_fault = 0; m_zone = '0; m_ok = 1;
      end else if (!enable) begin
        m_pos = 0;
      end else begin
        s_dat[m_pos] = int'(sensor_data[m_pos]);
        s_vld[m_pos] = sensor_valid[m_pos];
        if (m_pos == N - 1) begin
          model_sweep_end();
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_on = 1;
  initial begin
    forever begin
      @(negedge clk_app);
      if (cmp_on && m_ok) begin
        chk("avg",    int'(die_temperature_avg),     m_avg);
        chk("max",    int'(die_temperature_max),     m_max);
        chk("level",  int'(thermal_throttle_level),  m_level);
        chk("active", int'(thermal_throttle_active), int'(m_level != 0));
        chk("zones",  int'(thermal_zone_status),     int'(m_zone));
        chk("fault",  int'(sensor_fault),            int'(m_fault));
        chk("done",   int'(sweep_done),              int'(m_done));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_app);
  endtask

  task automatic fill(input int v, input bit vld);
    for (int i = 0; i < N; i++) begin
      sensor_data[i]  = TW'(v);
      sensor_valid[i] = vld;
    end
  endtask

  int base, nsw, mode;

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    fill(60, 1'b1);
    cycles(3);
    chk("rst_avg",   int'(die_temperature_avg), 25);
    chk("rst_max",   int'(die_temperature_max), 0);
    chk("rst_level", int'(thermal_throttle_level), 0);
    chk("rst_zones", int'(thermal_zone_status), 0);
    chk("rst_fault", int'(sensor_fault), 0);
    chk("rst_done",  int'(sweep_done), 0);

    // All at 60: results land exactly 64 cycles after enable.
    rst_n = 1'b1;
    enable = 1'b1;
    cycles(63);
    chk("first_done_early", int'(sweep_done), 0);
    cycles(1);
    chk("first_done",  int'(sweep_done), 1);
    chk("first_avg",   int'(die_temperature_avg), 60);
    chk("first_max",   int'(die_temperature_max), 60);
    chk("first_level", int'(thermal_throttle_level), 0);

    // Sensor 17 hot: avg 3890>>6 = 60, zone 2 alarmed, heavy throttle.
    sensor_data[17] = 8'd110;
    cycles(1);
    chk("done_pulse", int'(sweep_done), 0);
    cycles(63);
    chk("hot_avg",    int'(die_temperature_avg), 60);
    chk("hot_max",    int'(die_temperature_max), 110);
    chk("hot_level",  int'(thermal_throttle_level), 3);
    chk("hot_active", int'(thermal_throttle_active), 1);
    chk("hot_zones",  int'(thermal_zone_status), 'h04);

    // 99 from HEAVY: step to MEDIUM after exactly 4 qualifying sweeps.
    fill(99, 1'b1);
    cycles(64 * 3);
    chk("dwell3_level", int'(thermal_throttle_level), 3);
    cycles(64);
    chk("dwell4_level", int'(thermal_throttle_level), 2);
    // 90 is not below 95-5, so MEDIUM holds.
    fill(90, 1'b1);
    cycles(64 * 6);
    chk("hold_level", int'(thermal_throttle_level), 2);

    // No valid sensors: fault, forced HEAVY, temperatures held.
    fill(90, 1'b0);
    cycles(64);
    chk("fault_flag",  int'(sensor_fault), 1);
    chk("fault_level", int'(thermal_throttle_level), 3);
    chk("fault_avg",   int'(die_temperature_avg), 90);
    chk("fault_max",   int'(die_temperature_max), 90);
    fill(80, 1'b1);
    cycles(64);
    chk("fault_clear", int'(sensor_fault), 0);
    chk("clear_avg",   int'(die_temperature_avg), 80);

    // Invalid sensor substitutes the prior average: (63*80+70)>>6 = 79.
    fill(70, 1'b1);
    cycles(64);
    chk("prior_avg", int'(die_temperature_avg), 70);
    fill(80, 1'b1);
    sensor_valid[5] = 1'b0;
    cycles(64);
    chk("subst_avg", int'(die_temperature_avg), 79);

    // Enable drop at index 30 discards the partial sweep.
    fill(60, 1'b1);
    cycles(30);
    enable = 1'b0;
    cycles(5);
    chk("en_off_avg", int'(die_temperature_avg), 79);
    enable = 1'b1;
    cycles(63);
    chk("en_done_early", int'(sweep_done), 0);
    cycles(1);
    chk("en_done", int'(sweep_done), 1);
    chk("en_avg",  int'(die_temperature_avg), 60);

    // Reset mid-sweep.
    cycles(20);
    rst_n = 1'b0;
    cycles(2);
    chk("mrst_avg",   int'(die_temperature_avg), 25);
    chk("mrst_level", int'(thermal_throttle_level), 0);
    rst_n = 1'b1;
    cycles(63);
    chk("mrst_done_early", int'(sweep_done), 0);
    cycles(1);
    chk("mrst_done", int'(sweep_done), 1);
    chk("mrst_max",  int'(die_temperature_max), 60);

    // Randomized phase: temperature plateaus, sparse validity, late changes
    // to already-scanned sensors, and occasional enable drops.
    for (int g = 0; g < 12; g++) begin
      base = $urandom_range(50, 115);
      nsw  = $urandom_range(1, 6);
      mode = $urandom_range(0, 9);
      for (int s = 0; s < nsw; s++) begin
        for (int i = 0; i < N; i++) begin
          sensor_data[i]  = TW'(base - 4 + $urandom_range(0, 8));
          sensor_valid[i] = (mode == 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
        end
        for (int c = 0; c < N; c++) begin
          @(negedge clk_app);
          if ($urandom_range(0, 15) == 0)
            sensor_data[$urandom_range(0, N - 1)] = TW'($urandom_range(0, 255));
          if ($urandom_range(0, 199) == 0) begin
            enable = 1'b0;
            cycles($urandom_range(1, 4));
            enable = 1'b1;
          end
        end
      end
    end

    cycles(2);
    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
